bcd_operand_entry: RTL
======================

Name: bcd_operand_entry

Overview:
Parametrised push-button operand entry unit for the calculator front end: five raw buttons are debounced in the fast clock domain and edit NUM_OPERANDS signed decimal operands digit-by-digit. Each operand is held as BCD digits plus a sign for the 7-segment path. After every edit, a sequential BCD-to-binary converter produces a two's-complement value and issues a one-cycle write toward operand storage (BRAM, address = operand index). Generalises the fixed 3-digit, 2-operand entry path: configurable digit count, operand count, data width and debounce time, with per-operand banks.

Parameters:
NUM_DIGITS, 3, decimal magnitude digits per operand (1..4)
NUM_OPERANDS, 2, operand slots (2..4)
DATA_WIDTH, 16, two's-complement width of value/wr_data; elaboration error if 10^NUM_DIGITS-1 > 2^(DATA_WIDTH-1)-1
DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles before a button level is accepted (>=2)

Ports:
clk  in  1  system clock (100 MHz)
reset  in  1  synchronous, active-high reset
bt_C  in  1  raw centre button: next operand
bt_U  in  1  raw up: increment digit / toggle sign
bt_D  in  1  raw down: decrement digit / toggle sign
bt_L  in  1  raw left: cursor toward more significant
bt_R  in  1  raw right: cursor toward less significant
digits_out  out  4*NUM_DIGITS  BCD digits of selected operand, [3:0] = ones
sign_out  out  1  sign of selected operand, 1 = negative
cursor_out  out  clog2(NUM_DIGITS+1)  edit position; NUM_DIGITS = sign position
operand_sel  out  max(1,clog2(NUM_OPERANDS))  selected operand index
value_out  out  DATA_WIDTH  last converted value of selected operand
busy  out  1  conversion/write in progress
wr_en  out  1  one-cycle write strobe
wr_addr  out  max(1,clog2(NUM_OPERANDS))  write address = operand index
wr_data  out  DATA_WIDTH  two's-complement operand value

Behaviour:
- Reset (sync, active-high): all digit banks 0, all signs 0, cursor_out 0, operand_sel 0, value_out 0, wr_data 0, wr_addr 0, wr_en 0, busy 0, debounce counters 0, accepted levels 0. Reset during conversion aborts it; no wr_en issued.
- Debounce per button: counter counts cycles raw != accepted level, clears when they match; on reaching DEBOUNCE_CYCLES accepted level flips, counter clears. 0->1 accepted transition yields a one-cycle press pulse. Button held through reset: press pulse fires DEBOUNCE_CYCLES cycles after reset deasserts.
- Same-cycle press pulses: priority C > L > R > U > D; only the winner acts, others dropped.
- Presses while busy=1 are dropped (no state change).
- L: cursor+1, NUM_DIGITS wraps to 0. R: cursor-1, 0 wraps to NUM_DIGITS. No conversion triggered.
- U on digit: d==9 -> 0 else d+1; no carry. D on digit: d==0 -> 9 else d-1; no borrow. U or D on sign position toggles sign.
- C: operand_sel+1, NUM_OPERANDS-1 wraps to 0; cursor -> 0; target bank retains its contents.
- U, D or C = edit, applied in cycle E (registers update at end of E). FSM IDLE -> CONV -> SIGN -> WRITE -> IDLE:
  - CONV: cycles E+1..E+NUM_DIGITS, acc = acc*10 + digit, MSD first, acc cleared at entry. busy high from E+1.
  - SIGN: cycle E+NUM_DIGITS+1, acc negated if sign=1 and acc!=0 (negative zero converts to 0; sign_out still shows 1).
  - WRITE: cycle E+NUM_DIGITS+2, wr_en=1, wr_addr=operand index at edit, wr_data=result; value_out updates in the same cycle. busy drops the following cycle.
- wr_en is high exactly one cycle per edit; wr_addr/wr_data hold their last values otherwise.
- digits_out/sign_out/cursor_out reflect the edit from cycle E+1; operand_sel after C from E+1.

Test Plan:
- DEBOUNCE_CYCLES=4: bt_U pulse of 3 cycles -> no press, digits_out unchanged; held 4+ cycles -> exactly one press, ones 0->1, one wr_en at E+5 with wr_data=1, wr_addr=0.
- Ones=9, U -> ones=0, tens unchanged, wr_data=0; ones=0, D -> 9, wr_data=9.
- Enter digits 1,2,3 (hundreds..ones), L to sign position (cursor_out=3), U -> sign_out=1, wr_data=16'hFF85 (-123); D at sign -> +123 (16'h007B).
- C with operand 0 = -123 -> operand_sel=1, digits_out=0, wr_addr=1, wr_data=0; C again -> operand_sel=0, digits_out=123, sign_out=1, wr_data=-123.
- R at cursor 0 -> cursor 3; L at cursor 3 -> cursor 0; bt_L and bt_U accepted same cycle -> only cursor moves, no wr_en.
- Press arriving while busy=1 -> dropped; reset asserted in CONV -> no wr_en, all outputs 0 next cycle.

Source files
------------

// File: rtl/bcd_operand_entry_if.sv
// Write port toward operand storage: one-cycle strobe, address = operand index.
interface bcd_operand_entry_if #(
    parameter int AW = 1,
    parameter int DW = 16
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    modport master (output wr_en, output wr_addr, output wr_data);
    modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/bcd_operand_entry.sv
// Push-button operand entry: debounced buttons edit BCD operands, each edit is
// converted to two's complement and written out on the storage interface.

// Per-button debouncer; press is a one-cycle pulse on an accepted 0->1 change.
module bcd_operand_entry_db #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);
    localparam int CNTW = $clog2(CYCLES);

    logic [CNTW-1:0] cnt;
    logic            lvl;

    // Count consecutive cycles where raw disagrees with the accepted level.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            lvl   <= 1'b0;
            press <= 1'b0;
        end else begin
            press <= 1'b0;
            if (raw == lvl) begin
                cnt <= '0;
            end else if (cnt == CNTW'(CYCLES - 1)) begin
                lvl   <= raw;
                cnt   <= '0;
                press <= raw;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module bcd_operand_entry #(
    parameter int NUM_DIGITS      = 3,
    parameter int NUM_OPERANDS    = 2,
    parameter int DATA_WIDTH      = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    localparam int CW = $clog2(NUM_DIGITS + 1),
    localparam int SW = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    bt_C,
    input  logic                    bt_U,
    input  logic                    bt_D,
    input  logic                    bt_L,
    input  logic                    bt_R,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic                    sign_out,
    output logic [CW-1:0]           cursor_out,
    output logic [SW-1:0]           operand_sel,
    output logic [DATA_WIDTH-1:0]   value_out,
    output logic                    busy,
    bcd_operand_entry_if.master     wr
);
    localparam longint MAX_MAG = longint'(10 ** NUM_DIGITS) - 1;
    localparam longint MAX_POS = (longint'(1) <<< (DATA_WIDTH - 1)) - 1;

    generate
        if (MAX_MAG > MAX_POS) begin : g_width_err
            $error("DATA_WIDTH too small for NUM_DIGITS");
        end
    endgenerate

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CONV  = 2'd1;
    localparam logic [1:0] S_SIGN  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    // Button order: 4=C, 3=L, 2=R, 1=U, 0=D.
    logic [4:0] raw, press;
    assign raw = {bt_C, bt_L, bt_R, bt_U, bt_D};

    generate
        for (genvar i = 0; i < 5; i++) begin : g_db
            bcd_operand_entry_db #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
                .clk   (clk),
                .reset (reset),
                .raw   (raw[i]),
                .press (press[i])
            );
        end
    endgenerate

    logic [NUM_OPERANDS-1:0][4*NUM_DIGITS-1:0] bank;
    logic [NUM_OPERANDS-1:0]                   sgn;
    logic [NUM_OPERANDS-1:0][DATA_WIDTH-1:0]   vbank;
    logic [CW-1:0]         cursor, dsel, di;
    logic [SW-1:0]         sel, next_sel, conv_op;
    logic [1:0]            state;
    logic [DATA_WIDTH-1:0] acc, res;
    logic [3:0]            cur_dig, conv_dig;
    logic                  at_sign, idle;
    logic                  do_c, do_l, do_r, do_u, do_d;
    logic [4:0]            act;

    assign idle     = (state == S_IDLE);
    assign act      = press & {5{idle}};
    assign do_c     = act[4];
    assign do_l     = !act[4] && act[3];
    assign do_r     = (act[4:3] == 2'b00) && act[2];
    assign do_u     = (act[4:2] == 3'b000) && act[1];
    assign do_d     = (act[4:1] == 4'b0000) && act[0];

    assign at_sign  = (cursor == CW'(NUM_DIGITS));
    assign dsel     = at_sign ? '0 : cursor;
    assign cur_dig  = bank[sel][4*dsel +: 4];
    assign next_sel = (sel == SW'(NUM_OPERANDS - 1)) ? '0 : sel + 1'b1;
    assign conv_dig = bank[conv_op][4*di +: 4];
    // Negative zero collapses to 0.
    assign res      = (sgn[conv_op] && acc != '0) ? -acc : acc;

    // Cursor / operand select / digit and sign edits, one winner per cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            bank   <= '0;
            sgn    <= '0;
            cursor <= '0;
            sel    <= '0;
        end else if (do_c) begin
            sel    <= next_sel;
            cursor <= '0;
        end else if (do_l) begin
            cursor <= at_sign ? '0 : cursor + 1'b1;
        end else if (do_r) begin
            cursor <= (cursor == '0) ? CW'(NUM_DIGITS) : cursor - 1'b1;
        end else if (do_u || do_d) begin
            if (at_sign)
                sgn[sel] <= ~sgn[sel];
            else if (do_u)
                bank[sel][4*dsel +: 4] <= (cur_dig == 4'd9) ? 4'd0 : cur_dig + 4'd1;
            else
                bank[sel][4*dsel +: 4] <= (cur_dig == 4'd0) ? 4'd9 : cur_dig - 4'd1;
        end
    end

    // Converter: MSD-first acc*10+digit, sign fix-up, then one write cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            acc        <= '0;
            di         <= '0;
            conv_op    <= '0;
            vbank      <= '0;
            wr.wr_addr <= '0;
            wr.wr_data <= '0;
        end else begin
            case (state)
                S_IDLE: if (do_c || do_u || do_d) begin
                    state   <= S_CONV;
                    acc     <= '0;
                    di      <= CW'(NUM_DIGITS - 1);
                    conv_op <= do_c ? next_sel : sel;
                end
                S_CONV: begin
                    acc <= acc * DATA_WIDTH'(10) + DATA_WIDTH'(conv_dig);
                    if (di == '0) state <= S_SIGN;
                    else          di    <= di - 1'b1;
                end
                S_SIGN: begin
                    wr.wr_data     <= res;
                    wr.wr_addr     <= conv_op;
                    vbank[conv_op] <= res;
                    state          <= S_WRITE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign wr.wr_en    = (state == S_WRITE);
    assign busy        = !idle;
    assign digits_out  = bank[sel];
    assign sign_out    = sgn[sel];
    assign cursor_out  = cursor;
    assign operand_sel = sel;
    assign value_out   = vbank[sel];
endmodule
